// File: rtl/timer_scheduler.sv
// timer_scheduler
// Shares one countdown timer between NUM_REQ requesters using round-robin
// arbitration. The scheduler grants one requester at a time. It loads the
// timer with that requester's delay, runs the timer down to zero, and then
// returns a one-cycle done pulse to the owner.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req                 per-requester request level
//   req_ms              packed delays, requester i uses [i*W +: W]
//   grant               one-hot owner of the timer (LOAD/RUN)
//   done                one-hot, one-cycle expiry pulse to the owner
//   busy                high while not IDLE
//   timer_stop          parks/loads the timer (loads timer_start_value)
//   timer_enable        lets the timer count
//   timer_start_value   latched delay of the current owner
//   timer_value         current count from the timer
module timer_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int MAX_MS  = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [NUM_REQ*$clog2(MAX_MS)-1:0]   req_ms,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [NUM_REQ-1:0]                  done,
   output logic                                busy,
   output logic                                timer_stop,
   output logic                                timer_enable,
   output logic [$clog2(MAX_MS)-1:0]           timer_start_value,
   input  logic [$clog2(MAX_MS)-1:0]           timer_value
);

   localparam int W  = $clog2(MAX_MS);
   localparam int PW = $clog2(NUM_REQ);
   localparam int IW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [W-1:0]    start_value_q, start_value_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [PW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic [PW-1:0]   next_ptr;
   logic [NUM_REQ-1:0] owner_onehot;

   // Round-robin search starting at rr_ptr_q. The wrap is done with a
   // compare-and-subtract so that NUM_REQ need not be a power of two.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr_q} + IW'(i);
         if (cand >= IW'(NUM_REQ)) begin
            cand = cand - IW'(NUM_REQ);
         end
         if (!found && req[cand[PW-1:0]]) begin
            found = 1'b1;
            pick  = cand[PW-1:0];
         end
      end
   end

   assign next_ptr = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         start_value_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         start_value_q <= start_value_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state logic. A request dropped by the owner in LOAD/RUN wins
   // over a simultaneous timer expiry, so no done is issued.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      start_value_d = start_value_q;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d       = S_LOAD;
               owner_d       = pick;
               start_value_d = req_ms[pick*W +: W];
            end
         end
         S_LOAD: begin
            if (!req[owner_q]) begin
               state_d  = S_IDLE;
               rr_ptr_d = next_ptr;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!req[owner_q]) begin
               state_d  = S_IDLE;
               rr_ptr_d = next_ptr;
            end else if (timer_value == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            rr_ptr_d = next_ptr;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Output decode, from registers only
   always_comb begin
      owner_onehot      = NUM_REQ'(1) << owner_q;
      grant             = '0;
      done              = '0;
      timer_stop        = 1'b1;
      timer_enable      = 1'b0;
      busy              = busy_q;
      timer_start_value = start_value_q;
      unique case (state_q)
         S_LOAD: grant = owner_onehot;
         S_RUN: begin
            grant        = owner_onehot;
            timer_stop   = 1'b0;
            timer_enable = 1'b1;
         end
         S_DONE: done = owner_onehot;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_timer_scheduler.sv
module tb_timer_scheduler;

   localparam int NUM_REQ     = 4;
   localparam int MAX_MS      = 16;
   localparam int W           = 4;
   localparam int CLKS_PER_MS = 10;

   logic                 clk    = 1'b0;
   logic                 reset  = 1'b1;
   logic [NUM_REQ-1:0]   req    = '0;
   logic [NUM_REQ*W-1:0] req_ms = '0;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   done;
   logic                 busy;
   logic                 timer_stop;
   logic                 timer_enable;
   logic [W-1:0]         timer_start_value;
   logic [W-1:0]         timer_value = '0;
   int                   presc = 0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   timer_scheduler #(
      .NUM_REQ(NUM_REQ),
      .MAX_MS (MAX_MS)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req              (req),
      .req_ms           (req_ms),
      .grant            (grant),
      .done             (done),
      .busy             (busy),
      .timer_stop       (timer_stop),
      .timer_enable     (timer_enable),
      .timer_start_value(timer_start_value),
      .timer_value      (timer_value)
   );

   // Behavioural countdown timer: stop loads start_value and clears the
   // prescaler; enable decrements once every CLKS_PER_MS cycles, saturating at 0.
   always @(posedge clk) begin
      if (timer_stop) begin
         timer_value <= timer_start_value;
         presc       <= 0;
      end else if (timer_enable) begin
         if (presc == CLKS_PER_MS - 1) begin
            presc <= 0;
            if (timer_value != '0) timer_value <= timer_value - 1'b1;
         end else begin
            presc <= presc + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin : stim
      int lc;
      int n;
      logic [3:0] e;
      logic [3:0] en;

      // Reset state
      reset = 1'b1;
      step();
      step();
      chk("rst_grant", grant, 4'b0000);
      chk("rst_done", done, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stop", timer_stop, 1'b1);
      chk("rst_enable", timer_enable, 1'b0);
      chk("rst_start", timer_start_value, 4'd0);
      reset = 1'b0;
      step();

      // Single request, 5 ms
      req_ms[3:0] = 4'd5;
      req         = 4'b0001;
      step();
      chk("single_grant", grant, 4'b0001);
      chk("single_start", timer_start_value, 4'd5);
      chk("single_stop_load", timer_stop, 1'b1);
      chk("single_busy", busy, 1'b1);
      lc = 0;
      step();
      lc++;
      chk("single_run_en", timer_enable, 1'b1);
      chk("single_run_stop", timer_stop, 1'b0);
      chk("single_tv_loaded", timer_value, 4'd5);
      while (done == '0 && lc < 200) begin
         step();
         lc++;
      end
      chk("single_done", done, 4'b0001);
      chk("single_latency", lc, 52);
      chk("single_grant_off", grant, 4'b0000);
      chk("single_tv_zero", timer_value, 4'd0);
      req = 4'b0000;
      step();
      chk("single_done_pulse", done, 4'b0000);
      chk("single_idle", busy, 1'b0);

      // Zero delay on requester 2
      req_ms[11:8] = 4'd0;
      req          = 4'b0100;
      step();
      chk("zero_grant", grant, 4'b0100);
      chk("zero_start", timer_start_value, 4'd0);
      step();
      chk("zero_run_en", timer_enable, 1'b1);
      chk("zero_tv", timer_value, 4'd0);
      step();
      chk("zero_done", done, 4'b0100);
      chk("zero_en_off", timer_enable, 1'b0);
      chk("zero_grant_off", grant, 4'b0000);
      req = 4'b0000;
      step();
      chk("zero_en_idle", timer_enable, 1'b0);
      chk("zero_done_pulse", done, 4'b0000);

      // Reset in the middle of RUN (owner 3)
      req_ms[15:12] = 4'd5;
      req           = 4'b1000;
      step();
      chk("mrst_grant", grant, 4'b1000);
      step();
      chk("mrst_run", timer_enable, 1'b1);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      chk("mrst_grant0", grant, 4'b0000);
      chk("mrst_done0", done, 4'b0000);
      chk("mrst_busy0", busy, 1'b0);
      chk("mrst_stop", timer_stop, 1'b1);
      chk("mrst_en", timer_enable, 1'b0);
      chk("mrst_start", timer_start_value, 4'd0);
      reset  = 1'b0;
      req    = 4'b1111;
      req_ms = 16'h1111;
      step();
      chk("rr_first_grant", grant, 4'b0001);

      // Round-robin: 0,1,2,3,0 with a two-cycle done-to-grant gap
      for (int g = 0; g < 4; g++) begin
         e  = 4'b0001 << g;
         en = 4'b0001 << ((g + 1) % 4);
         n = 0;
         while (done == '0 && n < 60) begin
            step();
            n++;
         end
         chk("rr_done", done, e);
         step();
         chk("rr_gap_idle", grant, 4'b0000);
         step();
         chk("rr_next_grant", grant, en);
      end

      // Owner 0 drops its request in LOAD
      req = 4'b0000;
      step();
      chk("rr_abort_grant", grant, 4'b0000);
      chk("rr_abort_busy", busy, 1'b0);

      // Abort 20 cycles into RUN, pending requester 2 served next
      req_ms[7:4]  = 4'd7;
      req_ms[11:8] = 4'd2;
      req          = 4'b0110;
      step();
      chk("abort_grant", grant, 4'b0010);
      step();
      chk("abort_run", timer_enable, 1'b1);
      for (int i = 0; i < 19; i++) step();
      req = 4'b0100;
      step();
      chk("abort_grant_off", grant, 4'b0000);
      chk("abort_no_done", done, 4'b0000);
      chk("abort_stop", timer_stop, 1'b1);
      step();
      chk("abort_next_grant", grant, 4'b0100);
      n = 0;
      while (done == '0 && n < 100) begin
         step();
         n++;
      end
      chk("abort_next_done", done, 4'b0100);
      req = 4'b0000;
      step();

      // Abort in the same cycle the timer reaches zero (owner 3)
      req_ms[15:12] = 4'd1;
      req           = 4'b1000;
      step();
      chk("coinc_grant", grant, 4'b1000);
      step();
      n = 0;
      while (timer_value != '0 && n < 50) begin
         step();
         n++;
      end
      chk("coinc_tv_zero", timer_value, 4'd0);
      chk("coinc_in_run", timer_enable, 1'b1);
      req = 4'b0000;
      step();
      chk("coinc_no_done", done, 4'b0000);
      chk("coinc_grant_off", grant, 4'b0000);
      chk("coinc_idle", busy, 1'b0);
      step();
      chk("coinc_no_done_late", done, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
